// File: rtl/game_sequencer.sv
// Frame sequencer for the flap game: turns vsync into four per-frame phase
// strobes and runs the game-state machine, scoring and high-score tracking.
//
// state | meaning
// IDLE  | power-up attract mode, waiting for the first flap/start press
// PLAY  | game running; physics, collision and scoring active
// DYING | bird falling after a hit; counts DEATH_FRAMES physics frames
// OVER  | game finished; high score latched, waiting for a new press
module game_sequencer #(
  parameter logic        VS_POL       = 1'b0,
  parameter int unsigned DEATH_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync_in,
  input  logic       flap_btn,
  input  logic       start_btn,
  input  logic       collision,
  input  logic       pipe_passed,
  output logic [1:0] state,
  output logic       sample_stb,
  output logic       physics_stb,
  output logic       collide_stb,
  output logic       score_stb,
  output logic       flap_evt,
  output logic       game_reset,
  output logic [7:0] score,
  output logic [7:0] hi_score
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [7:0] DEATH_LOAD = 8'(DEATH_FRAMES);

  state_t     state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic       vs_prev_q, vs_prev_d;
  logic       flap_hist_q, flap_hist_d;
  logic       start_hist_q, start_hist_d;
  logic       pass_q, pass_d;
  logic [7:0] death_cnt_q, death_cnt_d;
  logic [7:0] score_q, score_d;
  logic [7:0] hi_score_q, hi_score_d;
  logic       sample_stb_q, sample_stb_d;
  logic       physics_stb_q, physics_stb_d;
  logic       collide_stb_q, collide_stb_d;
  logic       score_stb_q, score_stb_d;
  logic       flap_evt_q, flap_evt_d;
  logic       game_reset_q, game_reset_d;

  logic frame_start;
  logic flap_edge;
  logic start_edge;
  logic go_play;

  // Next-state logic for frame phasing, game FSM, counters and scores.
  always_comb begin
    frame_start = (vsync_in == VS_POL) && (vs_prev_q != VS_POL);
    flap_edge   = flap_btn  & ~flap_hist_q;
    start_edge  = start_btn & ~start_hist_q;
    go_play     = sample_stb_q && (state_q == ST_IDLE || state_q == ST_OVER)
                  && (flap_edge || start_edge);

    vs_prev_d = vsync_in;

    // phase 1..4 = sample, physics, collide, score slots; new frames ignored meanwhile
    phase_d = phase_q;
    if (phase_q == 3'd0) begin
      if (frame_start) phase_d = 3'd1;
    end else if (phase_q == 3'd4) begin
      phase_d = 3'd0;
    end else begin
      phase_d = phase_q + 3'd1;
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_OVER: if (go_play) state_d = ST_PLAY;
      ST_PLAY:          if (collide_stb_q && collision) state_d = ST_DYING;
      ST_DYING:         if (physics_stb_q && death_cnt_q <= 8'd1) state_d = ST_OVER;
      default:          state_d = ST_IDLE;
    endcase

    flap_hist_d  = flap_hist_q;
    start_hist_d = start_hist_q;
    if (sample_stb_q) begin
      flap_hist_d  = flap_btn;
      start_hist_d = start_btn;
    end

    // Strobes use state_d so a start press still gets this frame's physics step
    // and a collision suppresses this frame's score step.
    sample_stb_d  = (phase_q == 3'd0) && frame_start;
    physics_stb_d = (phase_q == 3'd1) && (state_d == ST_PLAY || state_d == ST_DYING);
    collide_stb_d = (phase_q == 3'd2) && (state_d == ST_PLAY);
    score_stb_d   = (phase_q == 3'd3) && (state_d == ST_PLAY);
    // state_q check keeps the starting press from also becoming a flap
    flap_evt_d    = sample_stb_q && (state_q == ST_PLAY) && flap_edge;
    game_reset_d  = go_play;

    // A pass arriving with score_stb sets the flag after the clear, so it
    // scores next frame.
    pass_d = pass_q;
    if (game_reset_q)     pass_d = 1'b0;
    else if (pipe_passed) pass_d = 1'b1;
    else if (score_stb_q) pass_d = 1'b0;

    score_d = score_q;
    if (game_reset_q)
      score_d = 8'd0;
    else if (score_stb_q && pass_q && score_q != 8'hFF)
      score_d = score_q + 8'd1;

    death_cnt_d = death_cnt_q;
    if (game_reset_q)
      death_cnt_d = 8'd0;
    else if (state_q == ST_PLAY && state_d == ST_DYING)
      death_cnt_d = DEATH_LOAD;
    else if (state_q == ST_DYING && physics_stb_q && death_cnt_q != 8'd0)
      death_cnt_d = death_cnt_q - 8'd1;

    hi_score_d = hi_score_q;
    if (state_q == ST_DYING && state_d == ST_OVER && score_q > hi_score_q)
      hi_score_d = score_q;
  end

  // All state and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      phase_q       <= 3'd0;
      vs_prev_q     <= ~VS_POL;
      flap_hist_q   <= 1'b0;
      start_hist_q  <= 1'b0;
      pass_q        <= 1'b0;
      death_cnt_q   <= 8'd0;
      score_q       <= 8'd0;
      hi_score_q    <= 8'd0;
      sample_stb_q  <= 1'b0;
      physics_stb_q <= 1'b0;
      collide_stb_q <= 1'b0;
      score_stb_q   <= 1'b0;
      flap_evt_q    <= 1'b0;
      game_reset_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      vs_prev_q     <= vs_prev_d;
      flap_hist_q   <= flap_hist_d;
      start_hist_q  <= start_hist_d;
      pass_q        <= pass_d;
      death_cnt_q   <= death_cnt_d;
      score_q       <= score_d;
      hi_score_q    <= hi_score_d;
      sample_stb_q  <= sample_stb_d;
      physics_stb_q <= physics_stb_d;
      collide_stb_q <= collide_stb_d;
      score_stb_q   <= score_stb_d;
      flap_evt_q    <= flap_evt_d;
      game_reset_q  <= game_reset_d;
    end
  end

  assign state       = state_q;
  assign sample_stb  = sample_stb_q;
  assign physics_stb = physics_stb_q;
  assign collide_stb = collide_stb_q;
  assign score_stb   = score_stb_q;
  assign flap_evt    = flap_evt_q;
  assign game_reset  = game_reset_q;
  assign score       = score_q;
  assign hi_score    = hi_score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: frame strobes, start/flap edges,
// scoring, death timing, high score and mid-frame reset.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync_in;
  logic       flap_btn;
  logic       start_btn;
  logic       collision;
  logic       pipe_passed;
  logic [1:0] state;
  logic       sample_stb, physics_stb, collide_stb, score_stb;
  logic       flap_evt, game_reset;
  logic [7:0] score, hi_score;

  int n_vec = 0;
  int n_err = 0;

  logic [19:0] pat;   // {sample,physics,collide,score} per cycle, N+1 in the MSBs
  logic [4:0]  fl;    // flap_evt per cycle N+1..N+5
  logic [4:0]  gr;    // game_reset per cycle N+1..N+5

  localparam logic [1:0] S_IDLE = 2'd0, S_PLAY = 2'd1, S_DYING = 2'd2, S_OVER = 2'd3;
  localparam logic [19:0] P_SAMPLE = 20'h80000;
  localparam logic [19:0] P_FULL   = 20'h84210;
  localparam logic [19:0] P_COLL   = 20'h84200;
  localparam logic [19:0] P_DYING  = 20'h84000;

  game_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync_in    (vsync_in),
    .flap_btn    (flap_btn),
    .start_btn   (start_btn),
    .collision   (collision),
    .pipe_passed (pipe_passed),
    .state       (state),
    .sample_stb  (sample_stb),
    .physics_stb (physics_stb),
    .collide_stb (collide_stb),
    .score_stb   (score_stb),
    .flap_evt    (flap_evt),
    .game_reset  (game_reset),
    .score       (score),
    .hi_score    (hi_score)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic cap();
    pat = {pat[15:0], sample_stb, physics_stb, collide_stb, score_stb};
    fl  = {fl[3:0], flap_evt};
    gr  = {gr[3:0], game_reset};
  endtask

  // One frame: vsync falls in cycle N, strobes captured N+1..N+5, one idle cycle.
  task automatic do_frame(input logic coll, input logic pipe_at_score);
    pat = '0; fl = '0; gr = '0;
    vsync_in  = 1'b0;
    collision = coll;
    tick(); cap();
    vsync_in = 1'b1;
    tick(); cap();
    tick(); cap();
    tick(); cap();
    if (pipe_at_score) pipe_passed = 1'b1;
    tick(); cap();
    pipe_passed = 1'b0;
    collision   = 1'b0;
    tick();
  endtask

  task automatic pulse_pipe(input int n);
    for (int i = 0; i < n; i++) begin
      pipe_passed = 1'b1;
      tick();
      pipe_passed = 1'b0;
      tick();
    end
  endtask

  task automatic scored_frames(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_pipe(1);
      do_frame(1'b0, 1'b0);
    end
  endtask

  task automatic dying_frames(input int n);
    for (int i = 0; i < n; i++) do_frame(1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; vsync_in = 1'b1; flap_btn = 1'b0; start_btn = 1'b0;
    collision = 1'b0; pipe_passed = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_strobes", 32'({sample_stb, physics_stb, collide_stb, score_stb, flap_evt, game_reset}), 32'h0);
    chk("rst_score", 32'(score), 32'h0);
    chk("rst_hi", 32'(hi_score), 32'h0);
    rst_n = 1'b1;
    tick(); tick();

    // idle frame: sample strobe only
    do_frame(1'b0, 1'b0);
    chk("idle_pattern", 32'(pat), 32'(P_SAMPLE));
    chk("idle_state", 32'(state), 32'(S_IDLE));

    // flap press starts the game, physics still runs, no flap event
    flap_btn = 1'b1;
    do_frame(1'b0, 1'b0);
    chk("start_pattern", 32'(pat), 32'(P_FULL));
    chk("start_greset", 32'(gr), 32'h08);
    chk("start_flap", 32'(fl), 32'h0);
    chk("start_state", 32'(state), 32'(S_PLAY));

    // held button is not a new edge
    do_frame(1'b0, 1'b0);
    chk("held_flap", 32'(fl), 32'h0);
    chk("held_greset", 32'(gr), 32'h0);
    flap_btn = 1'b0;
    do_frame(1'b0, 1'b0);
    flap_btn = 1'b1;
    do_frame(1'b0, 1'b0);
    chk("flap_evt", 32'(fl), 32'h08);
    chk("flap_pattern", 32'(pat), 32'(P_FULL));
    flap_btn = 1'b0;

    // three passes in one frame count once
    pulse_pipe(3);
    do_frame(1'b0, 1'b0);
    chk("multi_pass", 32'(score), 32'd1);
    do_frame(1'b0, 1'b0);
    chk("no_pass", 32'(score), 32'd1);
    scored_frames(4);
    chk("score5", 32'(score), 32'd5);

    // collision and pass together: collision wins
    pulse_pipe(1);
    do_frame(1'b1, 1'b0);
    chk("coll_pattern", 32'(pat), 32'(P_COLL));
    chk("coll_state", 32'(state), 32'(S_DYING));
    chk("coll_score", 32'(score), 32'd5);
    dying_frames(59);
    chk("dying59_state", 32'(state), 32'(S_DYING));
    do_frame(1'b0, 1'b0);
    chk("dying_pattern", 32'(pat), 32'(P_DYING));
    chk("over_state", 32'(state), 32'(S_OVER));
    chk("over_hi", 32'(hi_score), 32'd5);

    do_frame(1'b0, 1'b0);
    chk("over_idle_pattern", 32'(pat), 32'(P_SAMPLE));

    // start press from OVER; leftover pass flag must be cleared by game_reset
    start_btn = 1'b1;
    do_frame(1'b0, 1'b0);
    chk("restart_greset", 32'(gr), 32'h08);
    chk("restart_state", 32'(state), 32'(S_PLAY));
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_hi", 32'(hi_score), 32'd5);
    start_btn = 1'b0;

    // second game ends at 5: equal score leaves hi_score alone
    scored_frames(5);
    do_frame(1'b1, 1'b0);
    dying_frames(60);
    chk("game2_state", 32'(state), 32'(S_OVER));
    chk("game2_hi", 32'(hi_score), 32'd5);

    // third game: pass coincident with score_stb, then saturation
    flap_btn = 1'b1;
    do_frame(1'b0, 1'b0);
    flap_btn = 1'b0;
    chk("game3_score0", 32'(score), 32'd0);
    do_frame(1'b0, 1'b1);
    chk("late_pass_defer", 32'(score), 32'd0);
    do_frame(1'b0, 1'b0);
    chk("late_pass_count", 32'(score), 32'd1);
    scored_frames(254);
    chk("score255", 32'(score), 32'd255);
    scored_frames(1);
    chk("score_sat", 32'(score), 32'd255);
    do_frame(1'b1, 1'b0);
    dying_frames(60);
    chk("game3_hi", 32'(hi_score), 32'd255);

    // reset right after sample_stb in PLAY aborts the frame
    start_btn = 1'b1;
    do_frame(1'b0, 1'b0);
    start_btn = 1'b0;
    chk("pre_rst_state", 32'(state), 32'(S_PLAY));
    pat = '0;
    vsync_in = 1'b0;
    tick();
    chk("pre_rst_sample", 32'(sample_stb), 32'd1);
    rst_n    = 1'b0;
    vsync_in = 1'b1;
    tick(); cap();
    rst_n = 1'b1;
    tick(); cap();
    tick(); cap();
    tick(); cap();
    chk("rst_abort", 32'(pat[15:0]), 32'h0);
    chk("rst_mid_state", 32'(state), 32'(S_IDLE));
    chk("rst_mid_score", 32'(score), 32'd0);
    chk("rst_mid_hi", 32'(hi_score), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
